rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for a shared N:1 mux output path.
//   N requesters each present data plus a request. The block grants one requester at a time.
//   It drives the registered mux select and forwards the granted data with a valid/ready handshake.
//   It sits between the requester bank and the single downstream consumer of the muxed output.
// PARAMETERS
//   N     8             number of requesters; power of two, 2..16
//   W     1             data width per requester
//   SELW  $clog2(N)     select width; derived, do not override
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   req        in   N      request per requester; held high until its beat transfers
//   data       in   N*W    requester data; slice i = data[i*W +: W]
//   lock       in   N      hold grant after transfer (present only with RR_ARB_LOCK_EN)
//   gnt        out  N      one-hot grant, registered
//   sel        out  SELW   registered mux select = index of granted requester
//   out_valid  out  1      granted data valid
//   out_data   out  W      data[sel] when out_valid, else 0
//   out_ready  in   1      consumer accepts; transfer = out_valid & out_ready
// BEHAVIOUR
//   Reset (async, any time, incl. mid-transfer):
//   - state=IDLE, ptr=0, gnt=0, sel=0, out_valid=0, out_data=0.
//   - Release is synchronous to clk.
//   FSM: IDLE, BUSY.
//   Winner = first i with req[i]=1, scanning ptr, ptr+1, ... mod N.
//   IDLE:
//   - any req -> BUSY at next edge, with sel=winner and gnt=1<<winner.
//   - Grant latency: 1 cycle from req to gnt.
//   - no req -> stay IDLE, gnt=0.
//   BUSY:
//   - out_valid = req[sel] (combinational), out_data = data[sel] (combinational mux).
//   - Transfer:
//     - ptr <= sel+1 (wraps N-1 -> 0).
//     - Re-arbitrate in the same cycle with req[sel] masked.
//     - Winner found -> stay BUSY with new sel/gnt at next edge; no bubble cycle.
//     - None -> IDLE, gnt=0.
//   - req[sel] drops without transfer (abort): ptr <= sel+1, go IDLE, gnt=0 next edge.
//   - out_ready=0 with req[sel]=1: sel, gnt, out_data held stable; no re-arbitration.
//   Fairness and throughput:
//   - A continuously requesting line is granted within N grants.
//   - A lone requester gets one beat every 2 cycles (self-masking at transfer).
//   - req changes of non-granted lines while BUSY are ignored until the next arbitration.
//   - gnt is always one-hot or zero; sel is valid whenever gnt!=0.
// CONFIGURATION
//   RR_ARB_LOCK_EN defined:
//   - lock port exists.
//   - Transfer with lock[sel]=1: stay BUSY, same sel/gnt, ptr unchanged, no masking.
//   - Gives back-to-back beats every cycle.
//   - Transfer with lock[sel]=0 behaves as the normal transfer rule.
//   RR_ARB_LOCK_EN undefined:
//   - lock port absent; every grant is exactly one beat.
// TESTING
//   (N=8, W=1)
//   1. rst_n=0 with req=8'hFF -> gnt=0, sel=0, out_valid=0.
//      Assert rst_n=0 mid-BUSY -> same values immediately, before the next clk edge.
//   2. req=8'h20, out_ready=1 -> gnt=8'h20, sel=5, out_data=data[5] one cycle later.
//      After the transfer: gnt=0 for one cycle, then re-granted.
//   3. req=8'hFF, out_ready=1 constant -> sel sequence 0,1,2,...,7,0 on consecutive cycles.
//   4. req=8'h04, out_ready=0 for 4 cycles -> gnt=8'h04, sel=2, out_valid=1 held stable.
//      Then out_ready=1 -> one transfer; next grant search starts at 3.
//   5. Granted req[3] deasserts with out_ready=0 -> IDLE, gnt=0 next edge.
//      Then req=8'h09 -> grant goes to requester 0 (ptr=4 wraps).
//   6. RR_ARB_LOCK_EN defined: req=8'h12, lock[1]=1 for 3 beats -> sel=1 for 3 consecutive transfers.
//      Then lock[1]=0 -> next grant sel=4.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter and sequencer for a shared N:1 mux output path.
//   One requester is granted at a time; the granted requester's data is
//   forwarded to a single downstream consumer with a valid/ready handshake.
//
// Parameters
//   N     number of requesters (power of two, 2..16)
//   W     data width per requester
//   SELW  select width, derived from N
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   req        in   N     request per requester, held until its beat transfers
//   data       in   N*W   requester data, slice i = data[i*W +: W]
//   lock       in   N     keep the grant after a transfer (RR_ARB_LOCK_EN only)
//   gnt        out  N     registered one-hot grant (zero when idle)
//   sel        out  SELW  registered mux select = index of granted requester
//   out_valid  out  1     granted data valid (req[sel] while busy)
//   out_data   out  W     data[sel] when out_valid, else 0
//   out_ready  in   1     consumer accepts; transfer = out_valid & out_ready
//
// Build option
//   RR_ARB_LOCK_EN  when defined, adds the lock port: a transfer with
//                   lock[sel]=1 keeps the same grant for back-to-back beats.
// ---------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter  int N    = 8,
    parameter  int W    = 1,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      req,
    input  logic [N*W-1:0]    data,
`ifdef RR_ARB_LOCK_EN
    input  logic [N-1:0]      lock,
`endif
    output logic [N-1:0]      gnt,
    output logic [SELW-1:0]   sel,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    input  logic              out_ready
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] r_sel;
    logic [N-1:0]    r_gnt;

    state_t          w_state_nxt;
    logic [SELW-1:0] w_ptr_nxt;
    logic [SELW-1:0] w_sel_nxt;
    logic [N-1:0]    w_gnt_nxt;
    logic [SELW-1:0] w_sel_p1;
    logic [N-1:0]    w_req_masked;
    logic            w_req_sel;
    logic            w_lock_sel;

    // One-hot decode of an index.
    function automatic logic [N-1:0] f_onehot(input logic [SELW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requester at or after 'start', wrapping modulo N. Scanning from
    // the far end backwards lets the nearest hit overwrite the others, so no
    // early exit is needed. Result is don't-care when r is all zero.
    function automatic logic [SELW-1:0] f_winner(input logic [N-1:0]    r,
                                                 input logic [SELW-1:0] start);
        logic [SELW-1:0] idx;
        logic [SELW-1:0] win;
        win = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = start + SELW'(k);   // wraps naturally since N is a power of two
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    assign w_sel_p1     = r_sel + SELW'(1);
    assign w_req_sel    = req[r_sel];
    // Masking the just-served line makes a lone requester see one idle
    // cycle between beats, which is what gives the others a fair chance.
    assign w_req_masked = req & ~f_onehot(r_sel);

`ifdef RR_ARB_LOCK_EN
    assign w_lock_sel = lock[r_sel];
`else
    assign w_lock_sel = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        unique case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = f_winner(req, r_ptr);
                    w_gnt_nxt   = f_onehot(f_winner(req, r_ptr));
                end else begin
                    w_gnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (!w_req_sel) begin
                    // Requester withdrew before its beat was taken.
                    w_ptr_nxt   = w_sel_p1;
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end else if (out_ready) begin
                    if (!w_lock_sel) begin
                        w_ptr_nxt = w_sel_p1;
                        if (|w_req_masked) begin
                            w_sel_nxt = f_winner(w_req_masked, w_sel_p1);
                            w_gnt_nxt = f_onehot(f_winner(w_req_masked, w_sel_p1));
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_gnt_nxt   = '0;
                        end
                    end
                end
                // out_ready low: everything holds, no re-arbitration.
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign out_valid = (r_state == ST_BUSY) && w_req_sel;
    assign out_data  = out_valid ? data[r_sel*W +: W] : '0;

endmodule
